bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin_to_bcd_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Each clock processes one binary bit. The result feeds a multiplexed
// 7-segment driver, so the display needs no /10 or %10 logic of its own.
//
// Ports
//   clk_12MHz  in   1         system clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   start      in   1         conversion request, only sampled while idle
//   bin_in     in   BIN_W     binary value, captured on the accepting edge
//   busy       out  1         conversion in progress
//   done       out  1         one-cycle pulse when bcd_out/overflow update
//   bcd_out    out  4*DIGITS  packed BCD, [3:0] = ones digit
//   overflow   out  1         last captured value exceeded 10^DIGITS-1
//
// bcd_out and overflow are written only in FINISH or by reset. This lets the
// display scan sample them at any time.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk_12MHz,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [31:0]      MAX_VAL  = 32'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [SCR_W-1:0]   scratch;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_pend;

    // One double-dabble iteration. Every BCD nibble that is >= 5 gets 3
    // added first, then the whole scratch shifts left by one bit. The add
    // is a 4-bit add. Nibbles can only wrap for out-of-range inputs, and
    // those results are replaced by the clamp.
    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] t;
        t = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[BIN_W + 4*d +: 4] >= 4'd5)
                t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
        end
        return {t[SCR_W-2:0], 1'b0};
    endfunction

    // Saturate to all nines when the input was out of range.
    function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] bcd,
                                                 input logic             ovf);
        return ovf ? {DIGITS{4'h9}} : bcd;
    endfunction

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scratch  <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done may still be high in this cycle. Accepting start
                    // here is what allows back-to-back conversions.
                    if (start) begin
                        scratch  <= {{BCD_W{1'b0}}, bin_in};
                        ovf_pend <= ({{(32-BIN_W){1'b0}}, bin_in} > MAX_VAL);
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= dabble_step(scratch);
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_CNT)
                        state <= FINISH;
                end
                FINISH: begin
                    bcd_out  <= sat_bcd(scratch[SCR_W-1 -: BCD_W], ovf_pend);
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
